// File: rtl/mpt_pkg.sv
// Shared types for the PLB port arbiter: requester IDs, flush FSM states and
// a saturating-increment helper used by the optional counters.
package mpt_pkg;

  typedef enum logic {
    PLB_SRC_LOOKUP = 1'b0,
    PLB_SRC_REFILL = 1'b1
  } plb_arb_src_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } plb_flush_state_e;

  localparam int PLB_ARB_PERF_W = 32;

  function automatic logic [PLB_ARB_PERF_W-1:0] sat_inc(input logic [PLB_ARB_PERF_W-1:0] v);
    return (&v) ? v : v + PLB_ARB_PERF_W'(1);
  endfunction

endpackage

// File: rtl/plb_arb_id_fifo.sv
// 1-bit wide source-ID FIFO; records which requester owns each outstanding
// PLB access so responses can be routed back in order.
module plb_arb_id_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic                     data_i,
  output logic                     full_o,
  output logic                     empty_o,
  output logic                     head_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DEPTH-1:0] mem_q, mem_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full_o  = (cnt_q == (PTR_W+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = cnt_q;

  // Guarded internally so an overrun or underrun can never corrupt the count.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = data_i;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    cnt_d = cnt_q + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/plb_port_arbiter.sv
// Shares the PLB MEM port between the lookup (read) and refill (write) masters
// and sequences PLB flushes. Optional counters: define PLB_ARB_PERF_CNT_EN.
module plb_port_arbiter
  import mpt_pkg::*;
#(
  parameter int DATA_WIDTH      = 64,
  parameter int ADDR_WIDTH      = 64,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      lkp_slave_mem_req,
  output logic                      lkp_slave_mem_gnt,
  output logic                      lkp_slave_mem_valid,
  input  logic [ADDR_WIDTH-1:0]     lkp_slave_mem_addr,
  output logic [DATA_WIDTH-1:0]     lkp_slave_mem_rdata,
  output logic                      lkp_slave_mem_error,
  input  logic                      rfl_slave_mem_req,
  output logic                      rfl_slave_mem_gnt,
  output logic                      rfl_slave_mem_valid,
  input  logic [ADDR_WIDTH-1:0]     rfl_slave_mem_addr,
  input  logic [DATA_WIDTH-1:0]     rfl_slave_mem_wdata,
  input  logic                      rfl_slave_mem_we,
  input  logic [DATA_WIDTH/8-1:0]   rfl_slave_mem_be,
  output logic [DATA_WIDTH-1:0]     rfl_slave_mem_rdata,
  output logic                      rfl_slave_mem_error,
  output logic                      plb_master_mem_req,
  input  logic                      plb_master_mem_gnt,
  input  logic                      plb_master_mem_valid,
  output logic [ADDR_WIDTH-1:0]     plb_master_mem_addr,
  input  logic [DATA_WIDTH-1:0]     plb_master_mem_rdata,
  output logic [DATA_WIDTH-1:0]     plb_master_mem_wdata,
  output logic                      plb_master_mem_we,
  output logic [DATA_WIDTH/8-1:0]   plb_master_mem_be,
  input  logic                      plb_master_mem_error,
  input  logic                      flush_req_i,
  output logic                      flush_done_o,
  output logic                      plb_flush_o,
  input  logic                      plb_flush_ack_i,
  output logic                      protocol_error_o,
  output logic [PLB_ARB_PERF_W-1:0] perf_lkp_gnt_o,
  output logic [PLB_ARB_PERF_W-1:0] perf_rfl_gnt_o,
  output logic [PLB_ARB_PERF_W-1:0] perf_conflict_o,
  output logic [1:0]                dbg_flush_state_o
);

  localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1;

  // Handshake: a master holds req and its addr/wdata/we/be stable until it sees
  // gnt; each accepted request gets exactly one in-order valid from the PLB.

  plb_flush_state_e state_q;
  logic             plb_flush_q, flush_done_q;
  logic             lock_q, lock_d;
  plb_arb_src_e     lock_src_q, lock_src_d;
  plb_arb_src_e     rr_q, rr_d;
  logic             prot_err_q, prot_err_d;
  plb_arb_src_e     sel, head_src;
  logic             src_req, eligible, granted, push, pop, drained;
  logic             fifo_full, fifo_empty, fifo_head;
  logic [CNT_W-1:0] fifo_count, count_nxt;

  always_comb begin
    sel = PLB_SRC_LOOKUP;
    if (lock_q) begin
      sel = lock_src_q;
    end else if (lkp_slave_mem_req && rfl_slave_mem_req) begin
      sel = rr_q;
    end else if (rfl_slave_mem_req) begin
      sel = PLB_SRC_REFILL;
    end
  end

  assign src_req  = (sel == PLB_SRC_REFILL) ? rfl_slave_mem_req : lkp_slave_mem_req;
  assign eligible = (state_q == IDLE) && !fifo_full;
  // A locked request is always allowed through so DRAIN can finish it.
  assign plb_master_mem_req = src_req && (lock_q || eligible);
  assign granted            = plb_master_mem_req && plb_master_mem_gnt;
  assign lkp_slave_mem_gnt  = granted && (sel == PLB_SRC_LOOKUP);
  assign rfl_slave_mem_gnt  = granted && (sel == PLB_SRC_REFILL);

  assign plb_master_mem_addr  = (sel == PLB_SRC_REFILL) ? rfl_slave_mem_addr  : lkp_slave_mem_addr;
  assign plb_master_mem_wdata = (sel == PLB_SRC_REFILL) ? rfl_slave_mem_wdata : '0;
  assign plb_master_mem_we    = (sel == PLB_SRC_REFILL) ? rfl_slave_mem_we    : 1'b0;
  assign plb_master_mem_be    = (sel == PLB_SRC_REFILL) ? rfl_slave_mem_be    : '1;

  assign push     = granted;
  assign pop      = plb_master_mem_valid && !fifo_empty;
  assign head_src = plb_arb_src_e'(fifo_head);

  assign lkp_slave_mem_valid = pop && (head_src == PLB_SRC_LOOKUP);
  assign rfl_slave_mem_valid = pop && (head_src == PLB_SRC_REFILL);
  assign lkp_slave_mem_rdata = lkp_slave_mem_valid ? plb_master_mem_rdata : '0;
  assign rfl_slave_mem_rdata = rfl_slave_mem_valid ? plb_master_mem_rdata : '0;
  assign lkp_slave_mem_error = lkp_slave_mem_valid && plb_master_mem_error;
  assign rfl_slave_mem_error = rfl_slave_mem_valid && plb_master_mem_error;

  plb_arb_id_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_id_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  (sel),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .head_o  (fifo_head),
    .count_o (fifo_count)
  );

  always_comb begin
    lock_d     = lock_q;
    lock_src_d = lock_src_q;
    rr_d       = rr_q;
    if (granted) begin
      lock_d = 1'b0;
      rr_d   = (sel == PLB_SRC_LOOKUP) ? PLB_SRC_REFILL : PLB_SRC_LOOKUP;
    end else if (plb_master_mem_req) begin
      lock_d     = 1'b1;
      lock_src_d = sel;
    end
    prot_err_d = prot_err_q | (plb_master_mem_valid && fifo_empty);
  end

  // Drained means nothing locked and nothing outstanding after this edge.
  assign count_nxt = fifo_count + CNT_W'(push) - CNT_W'(pop);
  assign drained   = !lock_d && (count_nxt == '0);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      lock_q     <= 1'b0;
      lock_src_q <= PLB_SRC_LOOKUP;
      rr_q       <= PLB_SRC_LOOKUP;
      prot_err_q <= 1'b0;
    end else begin
      lock_q     <= lock_d;
      lock_src_q <= lock_src_d;
      rr_q       <= rr_d;
      prot_err_q <= prot_err_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      plb_flush_q  <= 1'b0;
      flush_done_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (flush_req_i) state_q <= DRAIN;
        end
        DRAIN: begin
          if (drained) begin
            state_q     <= FLUSH;
            plb_flush_q <= 1'b1;
          end
        end
        FLUSH: begin
          if (plb_flush_ack_i) begin
            state_q      <= DONE;
            plb_flush_q  <= 1'b0;
            flush_done_q <= 1'b1;
          end
        end
        DONE: begin
          state_q      <= IDLE;
          flush_done_q <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign plb_flush_o       = plb_flush_q;
  assign flush_done_o      = flush_done_q;
  assign protocol_error_o  = prot_err_q;
  assign dbg_flush_state_o = state_q;

`ifdef PLB_ARB_PERF_CNT_EN
  logic [PLB_ARB_PERF_W-1:0] perf_lkp_q, perf_lkp_d;
  logic [PLB_ARB_PERF_W-1:0] perf_rfl_q, perf_rfl_d;
  logic [PLB_ARB_PERF_W-1:0] perf_cfl_q, perf_cfl_d;

  always_comb begin
    perf_lkp_d = perf_lkp_q;
    perf_rfl_d = perf_rfl_q;
    perf_cfl_d = perf_cfl_q;
    if (lkp_slave_mem_gnt) perf_lkp_d = sat_inc(perf_lkp_q);
    if (rfl_slave_mem_gnt) perf_rfl_d = sat_inc(perf_rfl_q);
    // With both pending, at most one can be granted, so the other is denied.
    if (lkp_slave_mem_req && rfl_slave_mem_req) perf_cfl_d = sat_inc(perf_cfl_q);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      perf_lkp_q <= '0;
      perf_rfl_q <= '0;
      perf_cfl_q <= '0;
    end else begin
      perf_lkp_q <= perf_lkp_d;
      perf_rfl_q <= perf_rfl_d;
      perf_cfl_q <= perf_cfl_d;
    end
  end

  assign perf_lkp_gnt_o  = perf_lkp_q;
  assign perf_rfl_gnt_o  = perf_rfl_q;
  assign perf_conflict_o = perf_cfl_q;
`else
  assign perf_lkp_gnt_o  = '0;
  assign perf_rfl_gnt_o  = '0;
  assign perf_conflict_o = '0;
`endif

endmodule

// File: doc/plb_port_arbiter.md
Name: plb_port_arbiter

Overview:
Shares the single PLB (protection lookaside buffer) SRAM-style MEM port between two requesters. The lookup stage issues read-only tag probes; the refill path issues fill writes after a completed MPT walk. Sits between those two MEM master ports and the PLB cache. It arbitrates requests, keeps requests stable until granted, routes in-order responses back, and sequences PLB flushes by draining outstanding traffic first.

Parameters:
DATA_WIDTH, 64, PLB MEM rdata/wdata width
ADDR_WIDTH, 64, PLB MEM address (tag) width
MAX_OUTSTANDING, 4, granted-but-unanswered requests tracked (power of 2, >=2)

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset; synchronous, active-low, sampled on rising clk_i
lkp_slave_mem_req/gnt/valid/addr/rdata/error  in/out/out/in/out/out  1/1/1/ADDR/DATA/1  lookup MEM slave port; reads only, no we/be/wdata
rfl_slave_mem_req/gnt/valid/addr/wdata/we/be/rdata/error  in/out/out/in/in/in/in/out/out  1/1/1/ADDR/DATA/1/DATA/8/DATA/1  refill MEM slave port
plb_master_mem_req/gnt/valid/addr/rdata/wdata/we/be/error  out/in/in/out/in/out/out/out/in  1/1/1/ADDR/DATA/DATA/1/DATA/8/1  PLB cache port
flush_req_i  in  1  level request to flush the PLB
flush_done_o  out  1  one-cycle pulse when the flush completes
plb_flush_o  out  1  flush command to the PLB
plb_flush_ack_i  in  1  PLB flush acknowledge
protocol_error_o  out  1  sticky; set when valid arrives with no tracked request

Behaviour:
- Reset (rst_ni=0 at an edge) clears the following to 0 on that edge, whatever is in flight: all outputs, the FIFO, the lock, the RR pointer (favours lookup first), the FSM (IDLE) and protocol_error_o. In-flight responses are discarded.
- Arbitration (combinational, zero latency): eligible = FSM in IDLE and ID FIFO not full. Each MEM port drives req only while its source req is pending.
- Both requesters pending and unlocked: round-robin; the requester not granted last wins.
- Lock: if plb_master_mem_req=1 and gnt=0, register the selected source. Selection and addr/wdata/we/be stay fixed until gnt. This holds across a flush request (the DRAIN state honours the lock).
- Grant: the selected slave gnt = plb_master_mem_gnt. On gnt, push the source ID (0=lookup, 1=refill) into the ID FIFO, update the RR pointer and clear the lock.
- Lookup port forwards we=0, be='1, wdata=0.
- Response: plb_master_mem_valid pops the FIFO head. The head's source gets valid, rdata and error in the same cycle. The other source's valid=0 and rdata=0.
- Responses are strictly in order; no reordering.
- Valid with an empty FIFO: ignored, protocol_error_o<=1 (cleared only by reset).
- FIFO full: no new grant, even if a pop happens the same cycle (push blocked when full at cycle start). Outstanding count wraps only within 0..MAX_OUTSTANDING, never beyond.
- Same-cycle push and pop with the FIFO not full are both performed; the count is unchanged.
- Flush FSM:
  - IDLE -> DRAIN on flush_req_i.
  - DRAIN: no new unlocked grants; a locked request completes. Go to FLUSH when no lock is held and the FIFO is empty (a response arriving that cycle counts).
  - FLUSH: plb_flush_o=1 until plb_flush_ack_i; on ack go to DONE.
  - DONE: flush_done_o=1 for one cycle, then IDLE.
  - flush_req_i dropped mid-flush: the sequence still completes.
  - flush_req_i still high in IDLE after DONE: starts a new flush.

Optional Feature:
PLB_ARB_PERF_CNT_EN. When defined, adds three 32-bit saturating counters: lookup grants, refill grants, and conflict cycles (both reqs pending, one denied). They are exposed on outputs perf_lkp_gnt_o, perf_rfl_gnt_o and perf_conflict_o and cleared by reset. When undefined, these ports still exist, are tied to 0 and there are no counter flops.

Decomposition:
- mpt_pkg gets plb_arb_src_e (PLB_SRC_LOOKUP=0, PLB_SRC_REFILL=1) and plb_flush_state_e (IDLE, DRAIN, FLUSH, DONE).
- One sub-module: plb_arb_id_fifo, a synchronous FIFO of width 1 and depth MAX_OUTSTANDING with push, pop, full, empty and head outputs.

Test Plan:
1. Lookup only, addr 0x1000, PLB gnt same cycle, valid+rdata=1 next cycle -> lkp gnt in cycle 0; lkp valid=1 with rdata=1 in cycle 1; rfl valid=0.
2. Both req continuously, gnt always 1, valid one cycle later -> grants alternate L,R,L,R; each response goes to the matching source; perf_conflict increments every cycle (with macro).
3. Refill req with gnt held 0 for 3 cycles while lookup also requests -> addr, wdata and we=1 stable for all 3 cycles; refill granted first; lookup granted next.
4. gnt=1, valid withheld, 6 lookup requests -> exactly 4 grants, then req=0. After one valid, one more grant follows the next cycle.
5. flush_req_i with 2 outstanding -> no new grants; plb_flush_o rises the cycle after the last valid; ack 2 cycles later -> flush_done_o pulses once, then arbitration resumes.
6. Valid with empty FIFO -> protocol_error_o=1 and stays 1; rst_ni=0 for one edge mid-flush -> all outputs and the FSM return to 0/IDLE.
